// File: rtl/branch_resolve_pkg.sv
// Shared decode constants and helpers for the branch resolution stage.
// Opcode values and field layout match the fetch/decode instruction format.
package branch_resolve_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_JMP  = 6'h20;
  localparam logic [OPC_W-1:0] OP_BZ   = 6'h21;
  localparam logic [OPC_W-1:0] OP_BN   = 6'h22;
  localparam logic [OPC_W-1:0] OP_CALL = 6'h23;
  localparam logic [OPC_W-1:0] OP_RET  = 6'h24;

  localparam int PC_INITIAL = 0;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_JMP,
    BR_BZ,
    BR_BN,
    BR_CALL,
    BR_RET
  } br_kind_e;

  function automatic br_kind_e decode_op(input logic [OPC_W-1:0] op);
    br_kind_e kind;
    case (op)
      OP_JMP:  kind = BR_JMP;
      OP_BZ:   kind = BR_BZ;
      OP_BN:   kind = BR_BN;
      OP_CALL: kind = BR_CALL;
      OP_RET:  kind = BR_RET;
      default: kind = BR_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/branch_resolve_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// The top entry is read combinationally so a RET can redirect in the same cycle.
import branch_resolve_pkg::*;

module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             RST,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    sp_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    top_idx;

  // sp_q points at the next free slot; the top lives one below it.
  assign top_idx = sp_q - PW'(1);
  assign top_o   = mem_q[top_idx];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk_in) begin
    if (push_i) begin
      mem_q[sp_q] <= data_i;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      sp_q <= sp_q + PW'(1);
      if (!full_o) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (pop_i && !empty_o) begin
      sp_q  <= top_idx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage between fetch and decode: resolves jumps, branches,
// calls and returns, issues one-cycle PC redirects and squashes wrong-path slots.
import branch_resolve_pkg::*;

module branch_resolve #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [PC_WIDTH-1:0]    pc_next,
  input  logic                   flag_z,
  input  logic                   flag_n,
  input  logic                   flags_pend,
  output logic                   pc_chg,
  output logic [PC_WIDTH-1:0]    pc_in,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   valid_o,
  output logic                   ras_ovf,
  output logic                   ras_unf
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_WAIT} state_e;

  state_e                 state_q, state_d;
  logic                   pc_chg_q, pc_chg_d;
  logic [PC_WIDTH-1:0]    pc_in_q, pc_in_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic [PC_WIDTH-1:0]    wait_tgt_q, wait_tgt_d;
  logic [PC_WIDTH-1:0]    wait_pcn_q, wait_pcn_d;
  logic                   wait_bn_q, wait_bn_d;

  logic                   push, pop, ras_full, ras_empty;
  logic [PC_WIDTH-1:0]    ras_top;
  br_kind_e               kind;
  logic [PC_WIDTH-1:0]    target;
  logic                   cond_taken, wait_taken;

  assign kind       = decode_op(instr[INSTR_WIDTH-1 -: OPC_W]);
  assign target     = instr[PC_WIDTH-1:0];
  assign cond_taken = ((kind == BR_BZ) && flag_z) || ((kind == BR_BN) && flag_n);
  assign wait_taken = wait_bn_q ? flag_n : flag_z;

  ras_stack #(
    .WIDTH(PC_WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk_in (clk_in),
    .RST    (RST),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_next),
    .top_o  (ras_top),
    .full_o (ras_full),
    .empty_o(ras_empty)
  );

  always_comb begin
    state_d    = state_q;
    pc_chg_d   = 1'b0;
    pc_in_d    = pc_in_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    wait_tgt_d = wait_tgt_q;
    wait_pcn_d = wait_pcn_q;
    wait_bn_d  = wait_bn_q;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_RUN: begin
        valid_d = 1'b1;
        case (kind)
          BR_JMP: begin
            pc_chg_d = 1'b1;
            pc_in_d  = target;
            state_d  = S_FLUSH;
          end
          BR_BZ, BR_BN: begin
            if (flags_pend) begin
              wait_tgt_d = target;
              wait_pcn_d = pc_next;
              wait_bn_d  = (kind == BR_BN);
              state_d    = S_WAIT;
            end else if (cond_taken) begin
              pc_chg_d = 1'b1;
              pc_in_d  = target;
              state_d  = S_FLUSH;
            end
          end
          BR_CALL: begin
            push     = 1'b1;
            ovf_d    = ovf_q | ras_full;
            pc_chg_d = 1'b1;
            pc_in_d  = target;
            state_d  = S_FLUSH;
          end
          BR_RET: begin
            // An empty stack leaves nothing to return to, so the RET falls through.
            if (ras_empty) begin
              unf_d = 1'b1;
            end else begin
              pop      = 1'b1;
              pc_chg_d = 1'b1;
              pc_in_d  = ras_top;
              state_d  = S_FLUSH;
            end
          end
          default: ;
        endcase
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      S_WAIT: begin
        if (!flags_pend) begin
          pc_chg_d = 1'b1;
          pc_in_d  = wait_taken ? wait_tgt_q : wait_pcn_q;
          state_d  = S_FLUSH;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      state_q    <= S_RUN;
      pc_chg_q   <= 1'b0;
      pc_in_q    <= PC_WIDTH'(PC_INITIAL);
      instr_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      wait_tgt_q <= '0;
      wait_pcn_q <= '0;
      wait_bn_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_chg_q   <= pc_chg_d;
      pc_in_q    <= pc_in_d;
      instr_q    <= instr;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      wait_tgt_q <= wait_tgt_d;
      wait_pcn_q <= wait_pcn_d;
      wait_bn_q  <= wait_bn_d;
    end
  end

  assign pc_chg  = pc_chg_q;
  assign pc_in   = pc_in_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: a vector table plus hand-written
// sequences, each expectation queued at drive time and popped after the edge.
module tb_branch_resolve;

  logic        clk_in = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] instr = '0;
  logic [15:0] pc_next = '0;
  logic        flag_z = 1'b0, flag_n = 1'b0, flags_pend = 1'b0;
  logic        pc_chg, valid_o, ras_ovf, ras_unf;
  logic [15:0] pc_in;
  logic [31:0] instr_o;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pcn;
    logic        fz, fn, fp, rst_n;
    logic        chg;
    logic [15:0] pc;
    logic        chk_pc;
    logic        valid, ovf, unf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  branch_resolve #(.PC_WIDTH(16), .INSTR_WIDTH(32), .RAS_DEPTH(4)) dut (
    .clk_in(clk_in), .RST(RST), .instr(instr), .pc_next(pc_next),
    .flag_z(flag_z), .flag_n(flag_n), .flags_pend(flags_pend),
    .pc_chg(pc_chg), .pc_in(pc_in), .instr_o(instr_o), .valid_o(valid_o),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] tgt);
    return {op, 10'h000, tgt};
  endfunction

  function automatic logic [31:0] nop(input int n);
    return {6'h01, 10'h155, 16'(16'hA000 + n)};
  endfunction

  function automatic vec_t mv(input logic [31:0] ins, input logic [15:0] pcn,
                              input logic fz, input logic fn, input logic fp,
                              input logic rst_n, input logic chg,
                              input logic [15:0] pc, input logic chk_pc,
                              input logic valid, input logic ovf, input logic unf);
    vec_t v;
    v.instr = ins; v.pcn = pcn; v.fz = fz; v.fn = fn; v.fp = fp; v.rst_n = rst_n;
    v.chg = chg; v.pc = pc; v.chk_pc = chk_pc; v.valid = valid; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // Plain run-state slot: no redirect, pc_in not checked.
  function automatic vec_t pv(input logic [31:0] ins, input logic fp, input logic valid,
                              input logic ovf, input logic unf);
    return mv(ins, 16'h0, 1'b0, 1'b0, fp, 1'b1, 1'b0, 16'h0, 1'b0, valid, ovf, unf);
  endfunction

  // Redirecting slot.
  function automatic vec_t rv(input logic [31:0] ins, input logic [15:0] pcn,
                              input logic fz, input logic fn, input logic [15:0] pc,
                              input logic valid, input logic ovf, input logic unf);
    return mv(ins, pcn, fz, fn, 1'b0, 1'b1, 1'b1, pc, 1'b1, valid, ovf, unf);
  endfunction

  function automatic vec_t rstv();
    return mv(nop(99), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, want);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    instr = v.instr; pc_next = v.pcn;
    flag_z = v.fz; flag_n = v.fn; flags_pend = v.fp; RST = v.rst_n;
    exp_q.push_back(v);
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      cmp("pc_chg", idx, 32'(pc_chg), 32'(e.chg));
      cmp("valid_o", idx, 32'(valid_o), 32'(e.valid));
      cmp("instr_o", idx, instr_o, e.rst_n ? e.instr : 32'h0);
      cmp("ras_ovf", idx, 32'(ras_ovf), 32'(e.ovf));
      cmp("ras_unf", idx, 32'(ras_unf), 32'(e.unf));
      if (e.chk_pc) cmp("pc_in", idx, 32'(pc_in), 32'(e.pc));
      $display("[TB] step %0d instr=%h pc_chg=%0b pc_in=%h valid=%0b ovf=%0b unf=%0b",
               idx, instr_o, pc_chg, pc_in, valid_o, ras_ovf, ras_unf);
    end
  endtask

  initial begin
    // Reset and straight-line flow.
    vecs.push_back(rstv());
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mv(nop(i), 16'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    // JMP then one squashed slot.
    vecs.push_back(rv(mk(6'h20, 16'h0040), 16'h0011, 1'b0, 1'b0, 16'h0040, 1'b1, 1'b0, 1'b0));
    vecs.push_back(pv(nop(6), 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(7), 1'b0, 1'b1, 1'b0, 1'b0));
    // CALL / RET; a RET in the flush slot must not pop.
    vecs.push_back(rv(mk(6'h23, 16'h0080), 16'h0021, 1'b0, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b0));
    vecs.push_back(pv(mk(6'h24, 16'h0), 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(rv(mk(6'h24, 16'h0), 16'h0082, 1'b0, 1'b0, 16'h0021, 1'b1, 1'b0, 1'b0));
    vecs.push_back(pv(nop(8), 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(mk(6'h24, 16'h0), 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(pv(nop(9), 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(rstv());
    // Five CALLs overflow a 4-deep stack; the oldest return address is lost.
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(rv(mk(6'h23, 16'(16'h0100 + k)), 16'(16'h0050 + k), 1'b0, 1'b0,
                        16'(16'h0100 + k), 1'b1, (k == 4), 1'b0));
      vecs.push_back(pv(nop(10 + k), 1'b0, 1'b0, (k == 4), 1'b0));
    end
    for (int j = 0; j < 4; j++) begin
      vecs.push_back(rv(mk(6'h24, 16'h0), 16'(16'h0200 + j), 1'b0, 1'b0,
                        16'(16'h0054 - j), 1'b1, 1'b1, 1'b0));
      vecs.push_back(pv(nop(20 + j), 1'b0, 1'b0, 1'b1, 1'b0));
    end
    vecs.push_back(pv(mk(6'h24, 16'h0), 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(rstv());
    // BZ with pending flags, resolved not taken (flag_z toggles while pending).
    vecs.push_back(mv(mk(6'h21, 16'h0030), 16'h0061, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mv(nop(30), 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(31), 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(rv(nop(32), 16'h0, 1'b0, 1'b0, 16'h0061, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(33), 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(34), 1'b0, 1'b1, 1'b0, 1'b0));
    // Same branch, resolved taken.
    vecs.push_back(mv(mk(6'h21, 16'h0030), 16'h0062, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(pv(nop(35), 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(36), 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(rv(nop(37), 16'h0, 1'b1, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(38), 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(39), 1'b0, 1'b1, 1'b0, 1'b0));
    // BN taken without pending flags; BZ not taken without pending flags.
    vecs.push_back(rv(mk(6'h22, 16'h0044), 16'h0070, 1'b0, 1'b1, 16'h0044, 1'b1, 1'b0, 1'b0));
    vecs.push_back(pv(nop(40), 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mv(mk(6'h21, 16'h0045), 16'h0071, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(pv(nop(41), 1'b0, 1'b1, 1'b0, 1'b0));
    // Pending BN resolves on flag_n, not flag_z.
    vecs.push_back(mv(mk(6'h22, 16'h0046), 16'h0072, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(rv(nop(42), 16'h0, 1'b1, 1'b0, 16'h0072, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(43), 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(44), 1'b0, 1'b1, 1'b0, 1'b0));
    // A CALL squashed during WAIT must not push.
    vecs.push_back(mv(mk(6'h21, 16'h0047), 16'h0073, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(pv(mk(6'h23, 16'h0099), 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(rv(nop(45), 16'h0, 1'b1, 1'b0, 16'h0047, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(nop(46), 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(pv(mk(6'h24, 16'h0), 1'b0, 1'b1, 1'b0, 1'b1));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset in the middle of WAIT clears the FSM and the stack.
    step(rstv(), 100);
    step(rv(mk(6'h23, 16'h0010), 16'h0013, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0), 101);
    step(pv(nop(50), 1'b0, 1'b0, 1'b0, 1'b0), 102);
    step(mv(mk(6'h21, 16'h0030), 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0), 103);
    step(pv(nop(51), 1'b1, 1'b0, 1'b0, 1'b0), 104);
    step(rstv(), 105);
    step(rv(mk(6'h20, 16'h0077), 16'h0012, 1'b0, 1'b0, 16'h0077, 1'b1, 1'b0, 1'b0), 106);
    step(pv(nop(52), 1'b0, 1'b0, 1'b0, 1'b0), 107);
    step(pv(mk(6'h24, 16'h0), 1'b0, 1'b1, 1'b0, 1'b1), 108);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage immediately downstream of the fetch stage; the block that drives the fetch stage's `pc_chg`/`pc_in` redirect inputs.

- Consumes each fetched instruction and its fall-through PC (fetched PC + 1).
- Decodes jumps, conditional branches, calls and returns, and maintains a return-address stack.
- Issues one-cycle PC redirects and squashes wrong-path instructions before they reach decode.

## Interface
Parameters:
- PC_WIDTH, 16, program-counter width
- INSTR_WIDTH, 32, instruction width
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)

Ports:
- clk_in  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-low
- instr  in  INSTR_WIDTH  instruction from fetch, valid every cycle
- pc_next  in  PC_WIDTH  fall-through PC of `instr` (fetched PC + 1)
- flag_z, flag_n  in  1  committed zero/negative flags
- flags_pend  in  1  an in-flight older instruction will still write flags
- pc_chg  out  1  redirect request to fetch (registered)
- pc_in  out  PC_WIDTH  redirect target (registered)
- instr_o  out  INSTR_WIDTH  instruction to decode (registered)
- valid_o  out  1  `instr_o` is on the correct path
- ras_ovf, ras_unf  out  1  sticky stack overflow/underflow flags

## Operation
Decode:
- Opcode: `instr[INSTR_WIDTH-1 -: 6]`.
- Opcode values: JMP=6'h20, BZ=6'h21, BN=6'h22, CALL=6'h23, RET=6'h24; all others are non-branch.
- Target: `instr[PC_WIDTH-1:0]`, absolute.

State machine: RUN, FLUSH, WAIT.

RUN, instruction sampled at the edge:
- Non-branch, or BZ/BN not taken with `flags_pend=0`: pass through with `valid_o=1`, `pc_chg=0`.
- JMP, or BZ with `flag_z=1`, or BN with `flag_n=1`, with `flags_pend=0`: `pc_chg=1`, `pc_in=target`; go to FLUSH.
- CALL: push `pc_next`, redirect to target; go to FLUSH.
- RET with non-empty stack: pop; `pc_in` = popped value; go to FLUSH.
- RET with empty stack: set `ras_unf`, no redirect, treated as non-branch.
- BZ/BN with `flags_pend=1`:
  - Latch `pc_next`, target and condition type; go to WAIT.
  - The branch itself is forwarded with `valid_o=1`.
- Branch instructions are always forwarded downstream with `valid_o=1`.

FLUSH (exactly 1 cycle):
- Instruction sampled here is wrong-path: `valid_o=0`, decode ignored, no stack change.
- Return to RUN.

WAIT:
- All sampled instructions are squashed (`valid_o=0`).
- When `flags_pend=0` at an edge, evaluate the latched condition against current flags.
- Redirect with `pc_in` = taken ? latched target : latched `pc_next` (a not-taken branch re-fetches the fall-through).
- Go to FLUSH.

Return-address stack:
- Circular, RAS_DEPTH entries; pointer wraps.
- CALL when full: overwrite oldest entry, set `ras_ovf`, count stays RAS_DEPTH.
- Sticky flags clear only on reset.

Reset:
- RST=0 at an edge forces RUN, empty stack, `pc_chg=0`, `pc_in=0`, `instr_o=0`, `valid_o=0`, `ras_ovf=0`, `ras_unf=0`.
- Reset overrides any state, including WAIT/FLUSH mid-operation.

## Timing
- All outputs registered: instruction sampled at edge E appears on `instr_o`/`valid_o` and drives `pc_chg`/`pc_in` during cycle E..E+1.
- `pc_chg` is a single-cycle pulse; fetch loads `pc_in` at the following edge.
- Branch penalty: 1 squashed instruction without pending flags; 1 + (WAIT cycles) otherwise.
- No back-to-back redirects: FLUSH always separates two `pc_chg` pulses.
- Stack push and pop never occur in the same cycle (one instruction per cycle).

## Structure
- Opcode constants, field positions and PC_INITIAL belong in the shared `params_proc.v` include.
- FSM state encodings are local parameters.
- One sub-module: `ras_stack` (push/pop/full/empty, wrap-on-overflow), instantiated once.

## Test plan
- Straight-line: 5 non-branch instructions with `pc_next` 1..5 -> `instr_o` matches one cycle later, `valid_o=1`, `pc_chg` never asserted.
- JMP 0x0040 at `pc_next`=0x0011 -> next cycle `pc_chg=1`, `pc_in=0x0040`; following instruction `valid_o=0`; then RUN.
- CALL 0x0080 at `pc_next`=0x0021, later RET -> RET redirects to `pc_in=0x0021`; stack is then empty.
- 5 CALLs with RAS_DEPTH=4 -> `ras_ovf=1`; 4 RETs return the latest 4 `pc_next` values in LIFO order; a 5th RET sets `ras_unf=1` with no redirect.
- BZ 0x0030 with `flags_pend=1` for 3 cycles, then `flag_z=0` -> 3 squashed instructions, then `pc_chg=1`, `pc_in` = branch `pc_next`; repeat with `flag_z=1` -> `pc_in=0x0030`.
- RST=0 asserted during WAIT -> next cycle all outputs zero, stack empty; the next JMP redirects normally.
